// File: rtl/l2_bank_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l2_bank_arbiter_pkg
// Description : Shared constants, index type and round-robin pick helper
//               for the L2 bank arbiter and its ID FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package l2_bank_arbiter_pkg;

    // Number of masters sharing one L2 slave port; fixed per codebase build
    localparam int NR_MASTERS = 4;
    localparam int IDX_WIDTH  = $clog2(NR_MASTERS);

    typedef logic [IDX_WIDTH-1:0] idx_t;

    // First requesting master at or after ptr, searching cyclically.
    // Returns ptr when nobody requests; callers qualify with |req.
    function automatic idx_t rr_pick(input logic [NR_MASTERS-1:0] req,
                                     input idx_t                  ptr);
        idx_t pick;
        logic found;
        int   cand;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NR_MASTERS; i++) begin
            cand = (int'(ptr) + i) % NR_MASTERS;
            if (!found && req[cand]) begin
                pick  = idx_t'(cand);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/l2_arb_id_fifo.sv
`default_nettype none
// ============================================================================
// Module      : l2_arb_id_fifo
// Description : Small circular FIFO holding master indices of granted but
//               unanswered transactions. Push and pop may happen together.
// Revision    : 1.0 - initial release
// ============================================================================
module l2_arb_id_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_id,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_id,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head_id = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Pointer wrap that also works for depths that are not powers of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pointers and occupancy; simultaneous push/pop leaves the count as is
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_W'(1);
        end
    end

    // Storage needs no reset: entries are only read while occupied
    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_id;
    end

endmodule
`default_nettype wire

// File: rtl/l2_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : l2_bank_arbiter
// Description : Round-robin arbiter sharing one TCDM-style L2 slave port
//               between NR_MASTERS masters. An ID FIFO returns responses in
//               order to the issuing master with zero added latency.
//               Optional build macro L2_BANK_ARBITER_PERF_CNT_EN adds
//               conflict/stall performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module l2_bank_arbiter
    import l2_bank_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
`ifdef L2_BANK_ARBITER_PERF_CNT_EN
    input  logic                           clr_cnt_i,
    output logic [31:0]                    conflict_cnt_o,
    output logic [31:0]                    stall_cnt_o,
`endif
    input  logic [NR_MASTERS-1:0]          m_req_i,
    input  logic [NR_MASTERS*ADDR_WIDTH-1:0]     m_add_i,
    input  logic [NR_MASTERS-1:0]          m_wen_i,
    input  logic [NR_MASTERS*DATA_WIDTH-1:0]     m_wdata_i,
    input  logic [NR_MASTERS*DATA_WIDTH/8-1:0]   m_be_i,
    output logic [NR_MASTERS-1:0]          m_gnt_o,
    output logic [NR_MASTERS-1:0]          m_r_valid_o,
    output logic [DATA_WIDTH-1:0]          m_r_rdata_o,
    output logic                           s_req_o,
    output logic [ADDR_WIDTH-1:0]          s_add_o,
    output logic                           s_wen_o,
    output logic [DATA_WIDTH-1:0]          s_wdata_o,
    output logic [DATA_WIDTH/8-1:0]        s_be_o,
    input  logic                           s_gnt_i,
    input  logic                           s_r_valid_i,
    input  logic [DATA_WIDTH-1:0]          s_r_rdata_i
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    idx_t r_rr_ptr;
    idx_t w_winner;
    idx_t w_head;
    logic w_any_req;
    logic w_full;
    logic w_empty;
    logic w_accept;
    logic w_pop;

    assign w_any_req = |m_req_i;
    assign w_winner  = rr_pick(m_req_i, r_rr_ptr);
    // Blocking on full uses registered occupancy only, so the request never
    // depends combinationally on the slave's response valid
    assign s_req_o   = w_any_req & ~w_full;
    assign w_accept  = s_req_o & s_gnt_i;
    assign w_pop     = s_r_valid_i & ~w_empty;

    // Slave-side mux of the winning master; idle bus reads as a quiet read
    always_comb begin
        s_add_o   = '0;
        s_wen_o   = 1'b1;
        s_wdata_o = '0;
        s_be_o    = '0;
        if (w_any_req) begin
            s_add_o   = m_add_i[int'(w_winner)*ADDR_WIDTH +: ADDR_WIDTH];
            s_wen_o   = m_wen_i[w_winner];
            s_wdata_o = m_wdata_i[int'(w_winner)*DATA_WIDTH +: DATA_WIDTH];
            s_be_o    = m_be_i[int'(w_winner)*BE_WIDTH +: BE_WIDTH];
        end
    end

    // Master-side grant and response steering
    always_comb begin
        m_gnt_o     = '0;
        m_r_valid_o = '0;
        if (w_accept) m_gnt_o[w_winner]  = 1'b1;
        if (w_pop)    m_r_valid_o[w_head] = 1'b1;
    end

    assign m_r_rdata_o = s_r_rdata_i;

    // Round-robin pointer only moves past a master once it has been accepted
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= (int'(w_winner) == NR_MASTERS - 1) ? '0
                                                           : w_winner + idx_t'(1);
        end
    end

    l2_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDX_WIDTH)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .i_push    (w_accept),
        .i_push_id (w_winner),
        .i_pop     (w_pop),
        .o_head_id (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // A slave response with nothing outstanding cannot be routed anywhere
    a_orphan_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   s_r_valid_i |-> !w_empty)
        else $warning("l2_bank_arbiter: slave response with no outstanding transaction");

`ifdef L2_BANK_ARBITER_PERF_CNT_EN
    logic        w_conflict;
    logic        w_stall;
    logic [31:0] r_conflict_cnt;
    logic [31:0] r_stall_cnt;

    // More than one bit set: clearing the lowest set bit leaves something
    assign w_conflict = |(m_req_i & (m_req_i - NR_MASTERS'(1)));
    assign w_stall    = w_any_req & ~s_req_o;

    // Saturating event counters with synchronous clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_conflict_cnt <= '0;
            r_stall_cnt    <= '0;
        end else if (clr_cnt_i) begin
            r_conflict_cnt <= '0;
            r_stall_cnt    <= '0;
        end else begin
            if (w_conflict && (r_conflict_cnt != '1)) r_conflict_cnt <= r_conflict_cnt + 32'd1;
            if (w_stall && (r_stall_cnt != '1))       r_stall_cnt    <= r_stall_cnt + 32'd1;
        end
    end

    assign conflict_cnt_o = r_conflict_cnt;
    assign stall_cnt_o    = r_stall_cnt;
`endif

endmodule
`default_nettype wire
